fetch_stage: RTL and testbench

Front end of the pipelined core: owns the PC register, the run/halt control driven by `trigger`, and the IF/ID pipeline register.
- Drives the instruction-memory address (`pc_f`) and captures the returned word into IF/ID.
- Accepts branch/jump redirects from EX, plus stall and flush from the hazard unit.
- Replaces the current single-cycle PC block at the top level.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/if_id_reg.sv | 63 ++++++
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the fetch front end: FSM encodings, bubble/halt words, PC step.
package fetch_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] HALT_WORD_DEF  = 32'h0000_0073;  // ecall
  localparam int unsigned PC_INC         = 4;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush > stall > load > bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  stall_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] pc_plus4_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic                  valid_o
);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc4_q, pc4_d;
  logic                  valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i || (!stall_i && !load_i)) begin
      instr_d = NOP;
      pc_d    = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      pc4_d   = pc_plus4_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, IDLE/RUN/HALT control, IF/ID register and delivered-instruction counter.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD    = DATA_WIDTH'(HALT_WORD_DEF),
  parameter int unsigned           COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trigger,
  input  logic                   stall_f,
  input  logic                   stall_d,
  input  logic                   flush_d,
  input  logic                   pc_src_e,
  input  logic [ADDR_WIDTH-1:0]  pc_target_e,
  input  logic [DATA_WIDTH-1:0]  instr_i,
  output logic [ADDR_WIDTH-1:0]  pc_f,
  output logic [DATA_WIDTH-1:0]  instr_d,
  output logic [ADDR_WIDTH-1:0]  pc_d,
  output logic [ADDR_WIDTH-1:0]  pc_plus4_d,
  output logic                   valid_d,
  output logic                   running,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count
);
  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  fpc_q, fpc_d, fpc_plus4;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   cnt_clr, load, fill;

  assign fpc_plus4 = fpc_q + ADDR_WIDTH'(PC_INC);
  assign load      = (state_q == ST_RUN) && !stall_f;
  assign fill      = load && !flush_d && !stall_d;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        fpc_d = RESET_VECTOR;
        if (trigger) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (pc_src_e)
          fpc_d = pc_target_e;
        else if (!stall_f) begin
          // The halt word is still delivered to IF/ID; only the PC stops.
          if (instr_i == HALT_WORD) state_d = ST_HALT;
          else                      fpc_d   = fpc_plus4;
        end
      end
      ST_HALT: begin
        // An older branch resolving behind a speculative halt wins over restart.
        if (pc_src_e) begin
          fpc_d   = pc_target_e;
          state_d = ST_RUN;
        end else if (trigger) begin
          fpc_d   = RESET_VECTOR;
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fpc_d   = RESET_VECTOR;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)               cnt_d = '0;
    else if (fill && ~&cnt_q)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fpc_q   <= RESET_VECTOR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_d),
    .stall_i    (stall_d),
    .load_i     (load),
    .instr_i    (instr_i),
    .pc_i       (fpc_q),
    .pc_plus4_i (fpc_plus4),
    .instr_o    (instr_d),
    .pc_o       (pc_d),
    .pc_plus4_o (pc_plus4_d),
    .valid_o    (valid_d)
  );

  assign pc_f        = fpc_q;
  assign running     = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: main instance plus a 2-bit-counter instance for saturation.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0, stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [31:0] pc_target_e = '0;
  logic [31:0] halt_pc = 32'hFFFF_FFF0;
  logic [31:0] instr, pc_f, instr_d, pc_d, pc_plus4_d;
  logic        valid_d, running, halted;
  logic [15:0] fetch_count;

  logic        trigger2 = 1'b0;
  logic [31:0] instr2, pc_f2, instr_d2, pc_d2, pc_plus4_d2;
  logic        valid_d2, running2, halted2;
  logic [1:0]  fetch_count2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instruction memory: a tagged copy of the address, except the halt slot.
  assign instr  = (pc_f == halt_pc) ? 32'h0000_0073 : (32'h1000_0000 | pc_f);
  assign instr2 = 32'h1000_0000 | pc_f2;

  fetch_stage dut (
    .clk(clk), .rst(rst), .trigger(trigger), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .instr_i(instr),
    .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .running(running), .halted(halted), .fetch_count(fetch_count)
  );

  fetch_stage #(.COUNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .trigger(trigger2), .stall_f(1'b0), .stall_d(1'b0),
    .flush_d(1'b0), .pc_src_e(1'b0), .pc_target_e(32'h0), .instr_i(instr2),
    .pc_f(pc_f2), .instr_d(instr_d2), .pc_d(pc_d2), .pc_plus4_d(pc_plus4_d2),
    .valid_d(valid_d2), .running(running2), .halted(halted2), .fetch_count(fetch_count2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset, idle, start
    #12 rst = 1'b0;
    #1;
    chk("rst_pc", pc_f, 0);
    chk("rst_instr", instr_d, 32'h13);
    chk("rst_valid", valid_d, 0);
    chk("rst_cnt", fetch_count, 0);
    chk("rst_run", running, 0);
    chk("rst_halt", halted, 0);
    repeat (5) tick();
    chk("idle_pc", pc_f, 0);
    chk("idle_valid", valid_d, 0);
    chk("idle_run", running, 0);
    trigger = 1'b1; tick(); trigger = 1'b0;
    chk("start_run", running, 1);
    chk("start_pc", pc_f, 0);
    chk("start_valid", valid_d, 0);
    tick();
    chk("f1_pc", pc_f, 4);
    chk("f1_instr", instr_d, 32'h1000_0000);
    chk("f1_valid", valid_d, 1);
    chk("f1_cnt", fetch_count, 1);
    tick();
    chk("f2_pc", pc_f, 8);
    chk("f2_instr", instr_d, 32'h1000_0004);
    chk("f2_pcd", pc_d, 4);
    chk("f2_pc4d", pc_plus4_d, 8);
    chk("f2_cnt", fetch_count, 2);

    // 2. stall both for two cycles, then release
    stall_f = 1'b1; stall_d = 1'b1;
    repeat (2) tick();
    chk("stl_pc", pc_f, 8);
    chk("stl_instr", instr_d, 32'h1000_0004);
    chk("stl_pcd", pc_d, 4);
    chk("stl_cnt", fetch_count, 2);
    stall_f = 1'b0; stall_d = 1'b0;
    tick();
    chk("rel_pc", pc_f, 12);
    chk("rel_instr", instr_d, 32'h1000_0008);
    chk("rel_cnt", fetch_count, 3);

    // 3. redirect with flush, overriding stall_f
    pc_src_e = 1'b1; pc_target_e = 32'h40; flush_d = 1'b1; stall_f = 1'b1;
    tick();
    pc_src_e = 1'b0; flush_d = 1'b0; stall_f = 1'b0;
    chk("br_pc", pc_f, 32'h40);
    chk("br_valid", valid_d, 0);
    chk("br_instr", instr_d, 32'h13);
    chk("br_pcd", pc_d, 0);
    chk("br_cnt", fetch_count, 3);
    tick();
    chk("br2_pcd", pc_d, 32'h40);
    chk("br2_instr", instr_d, 32'h1000_0040);
    chk("br2_pc", pc_f, 32'h44);
    chk("br2_cnt", fetch_count, 4);

    // 4. halt word at 0x10, resume via redirect, then via trigger
    halt_pc = 32'h10;
    pc_src_e = 1'b1; pc_target_e = 32'h10; flush_d = 1'b1;
    tick();
    pc_src_e = 1'b0; flush_d = 1'b0;
    chk("h_pc0", pc_f, 32'h10);
    tick();
    chk("h_instr", instr_d, 32'h73);
    chk("h_valid", valid_d, 1);
    chk("h_halted", halted, 1);
    chk("h_run", running, 0);
    chk("h_pc", pc_f, 32'h10);
    chk("h_cnt", fetch_count, 5);
    tick();
    chk("h2_pc", pc_f, 32'h10);
    chk("h2_valid", valid_d, 0);
    chk("h2_cnt", fetch_count, 5);
    pc_src_e = 1'b1; pc_target_e = 32'h20;
    tick();
    pc_src_e = 1'b0;
    chk("hr_run", running, 1);
    chk("hr_pc", pc_f, 32'h20);
    chk("hr_valid", valid_d, 0);
    tick();
    chk("hr2_instr", instr_d, 32'h1000_0020);
    chk("hr2_pc", pc_f, 32'h24);
    chk("hr2_cnt", fetch_count, 6);
    pc_src_e = 1'b1; pc_target_e = 32'h10; flush_d = 1'b1;
    tick();
    pc_src_e = 1'b0; flush_d = 1'b0;
    tick();
    chk("h3_halted", halted, 1);
    chk("h3_cnt", fetch_count, 7);
    // redirect beats trigger: count survives
    trigger = 1'b1; pc_src_e = 1'b1; pc_target_e = 32'h30;
    tick();
    trigger = 1'b0; pc_src_e = 1'b0;
    chk("pri_pc", pc_f, 32'h30);
    chk("pri_cnt", fetch_count, 7);
    pc_src_e = 1'b1; pc_target_e = 32'h10; flush_d = 1'b1;
    tick();
    pc_src_e = 1'b0; flush_d = 1'b0;
    tick();
    chk("h4_halted", halted, 1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("ht_pc", pc_f, 0);
    chk("ht_cnt", fetch_count, 0);
    chk("ht_run", running, 1);
    tick();
    chk("ht2_instr", instr_d, 32'h1000_0000);
    chk("ht2_cnt", fetch_count, 1);
    halt_pc = 32'hFFFF_FFF0;

    // 5. wrap and asynchronous reset
    pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC; flush_d = 1'b1;
    tick();
    pc_src_e = 1'b0; flush_d = 1'b0;
    chk("wr_pc0", pc_f, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc", pc_f, 0);
    chk("wr_pcd", pc_d, 32'hFFFF_FFFC);
    chk("wr_pc4d", pc_plus4_d, 0);
    #2 rst = 1'b1;
    #1;
    chk("ar_pc", pc_f, 0);
    chk("ar_valid", valid_d, 0);
    chk("ar_instr", instr_d, 32'h13);
    chk("ar_pcd", pc_d, 0);
    chk("ar_cnt", fetch_count, 0);
    chk("ar_run", running, 0);
    #10 rst = 1'b0;
    tick();
    chk("ar_idle_run", running, 0);
    chk("ar_idle_pc", pc_f, 0);

    // 6. 2-bit counter saturates at 3
    trigger2 = 1'b1; tick(); trigger2 = 1'b0;
    chk("sat_run", running2, 1);
    repeat (2) tick();
    chk("sat_c2", fetch_count2, 2);
    tick();
    chk("sat_c3", fetch_count2, 3);
    repeat (2) tick();
    chk("sat_hold", fetch_count2, 3);
    chk("sat_pc", pc_f2, 32'h14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
